fp_result_stage: RTL
====================

// Module: fp_result_stage
// PURPOSE
//  Downstream consumer of the combinational FP add/sub/compare unit (results, compare[1:0]).
//  Turns raw adder outputs into architectural writeback values:
//   - FADD/FSUB sum.
//   - FEQ/FLT/FLE integer booleans.
//   - FMIN/FMAX selected operand.
//  Buffers them in a 2-entry FIFO with valid/ready handshakes toward the writeback mux.
//  Sits between the FP execute stage and the register-file writeback port.
// PARAMETERS
//  DEPTH     2   FIFO entries; only 2 is supported (1-bit pointers + 2-bit count).
//  CNT_W     32  width of the retired-op counter.
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  flush      in   1      sync; discard all buffered entries (branch/trap)
//  in_valid   in   1      execute stage presents an op
//  in_ready   out  1      stage can accept (count < DEPTH)
//  in_op      in   3      0 FADD, 1 FSUB, 2 FEQ, 3 FLT, 4 FLE, 5 FMIN, 6 FMAX, 7 reserved
//  in_rd      in   5      destination register index
//  in_a       in   32     operand a (IEEE-754 single)
//  in_b       in   32     operand b
//  in_result  in   32     adder sum/difference
//  in_compare in   2      0 a>b, 1 a<b, 2 a==b, 3 unordered/invalid
//  wb_valid   out  1      head entry valid
//  wb_ready   in   1      writeback accepts head
//  wb_rd      out  5      head destination
//  wb_data    out  32     head value
//  wb_to_int  out  1      1: integer regfile (FEQ/FLT/FLE); 0: FP regfile
//  retired    out  CNT_W  count of wb handshakes, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (rst_n=0, async): FIFO empty; pointers, count and retired = 0.
//    Reset outputs: wb_valid=0, wb_rd=0, wb_data=0, wb_to_int=0, in_ready=1.
//  - Push when in_valid&in_ready; pop when wb_valid&wb_ready. in_ready depends only on count (no comb path from wb_ready).
//  - Value is computed combinationally at push and stored; wb_* are driven from the head entry register.
//  - Latency: an op accepted in cycle N gives wb_valid=1 in cycle N+1 when the FIFO is empty.
//  - Push-data map:
//    - FADD/FSUB: data=in_result, to_int=0.
//    - FEQ: data=(compare==2); FLT: data=(compare==1); FLE: data=(compare==1|compare==2). These three: zero-extended, to_int=1.
//    - compare==3 forces FEQ/FLT/FLE data to 0.
//    - FMIN: compare==0 ? in_b : in_a.
//    - FMAX: compare==1 ? in_b : in_a. Equal or unordered selects in_a.
//    - op 7: entry is not pushed; in_ready still handshakes (op dropped).
//  - Count rules:
//    - Push+pop same cycle: count unchanged, both pointers advance (1-bit pointers wrap 1->0).
//    - Full (count=2): in_ready=0, any in_valid is held off.
//    - Empty: wb_valid=0; wb_data/wb_rd/wb_to_int hold the last popped entry's values.
//  - flush: next cycle count=0, ptrs=0, wb_valid=0. Overrides a same-cycle push; a same-cycle pop still increments retired.
//  - retired increments by 1 per pop handshake; it is not cleared by flush.
//  - Reset mid-operation drops all entries immediately (async), without waiting for a clock edge.
// CONFIGURATION
//  FP_RESULT_FWD_EN defined: adds outputs fwd_valid(1), fwd_rd(5), fwd_data(32) carrying the value being pushed in the
//    same cycle (combinational from inputs; fwd_valid=in_valid&in_ready&op!=7&!flush), for operand bypass in decode.
//  Undefined: no fwd_* ports exist; hazard logic must wait for writeback.
// TESTING
//  1. Reset: rst_n=0 mid-stream with 2 entries -> wb_valid=0, in_ready=1, retired=0 immediately.
//  2. FADD in_result=32'h40400000, rd=3, wb_ready=1 -> next cycle wb_valid=1, wb_data=32'h40400000, wb_rd=3, wb_to_int=0.
//  3. FLT compare=1 -> wb_data=1, to_int=1; FLE compare=2 -> 1; FEQ compare=0 -> 0; FEQ compare=3 -> 0.
//  4. FMIN a=32'h3F800000 b=32'hC0000000 compare=0 -> wb_data=32'hC0000000; FMAX same -> 32'h3F800000.
//  5. wb_ready=0, push 3 ops -> third stalled (in_ready=0 after 2). Then wb_ready=1 -> in order, retired=3.
//  6. Full FIFO, flush=1 with in_valid=1 -> next cycle wb_valid=0, count 0. With FP_RESULT_FWD_EN: fwd_valid=0 during flush.

Source files
------------

// File: rtl/fp_result_stage.sv
// rtl/fp_result_stage.sv - FP result formatting stage with 2-entry writeback FIFO
//
// Purpose: converts raw FP add/sub/compare outputs into architectural
//   writeback values (sum, integer boolean, or min/max operand) and buffers
//   them in a 2-entry FIFO toward the register-file writeback mux.
//
// Optional feature macro: FP_RESULT_FWD_EN
//   When defined, adds fwd_valid/fwd_rd/fwd_data carrying the value being
//   pushed this cycle, for operand bypass in decode.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      discard all buffered entries
//   in_valid/in_ready          execute-side handshake
//   in_op, in_rd               operation code, destination register
//   in_a, in_b, in_result      operands and adder result
//   in_compare                 0 a>b, 1 a<b, 2 a==b, 3 unordered
//   wb_valid/wb_ready          writeback-side handshake
//   wb_rd, wb_data, wb_to_int  head entry (to_int=1 selects integer regfile)
//   retired                    count of writeback handshakes (wraps)
//   fwd_valid/fwd_rd/fwd_data  same-cycle bypass (FP_RESULT_FWD_EN only)

module fp_result_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [31:0]      in_result,
  input  logic [1:0]       in_compare,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic             wb_to_int,
  output logic [CNT_W-1:0] retired
`ifdef FP_RESULT_FWD_EN
  ,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [31:0]      fwd_data
`endif
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [31:0] mem_data [2];
  logic [4:0]  mem_rd   [2];
  logic        mem_int  [2];

  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  // Last popped entry; shown on wb_* while the FIFO is empty.
  logic [31:0] last_data;
  logic [4:0]  last_rd;
  logic        last_int;

  logic [31:0] push_data;
  logic        push_int;
  logic        push;
  logic        pop;

  // Writeback value formatting. Unordered compare (3) matches none of the
  // boolean conditions, so FEQ/FLT/FLE naturally yield 0.
  always_comb begin
    push_data = '0;
    push_int  = 1'b0;
    case (in_op)
      3'd0, 3'd1: push_data = in_result;
      3'd2: begin
        push_data = {31'b0, in_compare == 2'd2};
        push_int  = 1'b1;
      end
      3'd3: begin
        push_data = {31'b0, in_compare == 2'd1};
        push_int  = 1'b1;
      end
      3'd4: begin
        push_data = {31'b0, (in_compare == 2'd1) | (in_compare == 2'd2)};
        push_int  = 1'b1;
      end
      3'd5:    push_data = (in_compare == 2'd0) ? in_b : in_a;
      3'd6:    push_data = (in_compare == 2'd1) ? in_b : in_a;
      default: push_data = '0;
    endcase
  end

  assign in_ready = (count != FULL);
  assign wb_valid = (count != 2'd0);

  // Op 7 still completes the input handshake but never occupies an entry.
  assign push = in_valid & in_ready & (in_op != 3'd7) & ~flush;
  assign pop  = wb_valid & wb_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      retired   <= '0;
      last_data <= '0;
      last_rd   <= '0;
      last_int  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
      // A pop coinciding with flush still retires the head.
      if (pop) begin
        retired   <= retired + CNT_W'(1);
        last_data <= mem_data[rd_ptr];
        last_rd   <= mem_rd[rd_ptr];
        last_int  <= mem_int[rd_ptr];
      end
    end
  end

  // Storage needs no reset: entries are only observed while count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_rd[wr_ptr]   <= in_rd;
      mem_int[wr_ptr]  <= push_int;
    end
  end

  assign wb_data   = wb_valid ? mem_data[rd_ptr] : last_data;
  assign wb_rd     = wb_valid ? mem_rd[rd_ptr]   : last_rd;
  assign wb_to_int = wb_valid ? mem_int[rd_ptr]  : last_int;

`ifdef FP_RESULT_FWD_EN
  assign fwd_valid = push;
  assign fwd_rd    = in_rd;
  assign fwd_data  = push_data;
`endif

endmodule
